// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers a two-digit value from a multiplexed, active-low 7-segment display scan.
module seg_scan_decoder #(
  parameter int STABLE_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [7:0] amt,
  output logic       amt_valid,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       pat_err
);
  typedef enum logic [1:0] {SYNC, HAVE0, HAVE1} state_t;
  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYC);
  localparam logic [7:0] CNT_STB = 8'(STABLE_CYC - 1);
  logic [1:0]  r_rst;
  logic        w_rst_n;
  logic [10:0] r_s1, r_s2, r_sd;
  logic [7:0]  r_cnt;
  logic        w_stb, w_d0, w_d1, w_up;
  logic [3:0]  w_an;
  logic [6:0]  w_seg;
  logic [3:0]  w_dig;
  logic        w_is_dig, w_blank;
  state_t      r_state, w_state_n;
  logic [3:0]  r_ones, r_tens, w_ones_n, w_tens_n;
  logic        r_ferr, w_ferr_n, w_valid_n, w_perr_n;
  logic [7:0]  w_frame;
  logic [7:0]  r_amt;
  logic [3:0]  r_digit0, r_digit1;
  logic        r_amt_valid, r_pat_err;
  // Assertion takes effect at once; deassertion is aligned to clk.
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_rst <= '0;
    else        r_rst <= {r_rst[0], 1'b1};
  assign w_rst_n = r_rst[1];
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_s1  <= '1;
      r_s2  <= '1;
      r_sd  <= '1;
      r_cnt <= '0;
    end else begin
      r_s1  <= {an, seg};
      r_s2  <= r_s1;
      r_sd  <= r_s2;
      r_cnt <= (r_s2 != r_sd) ? 8'd0 : (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 8'd1;
    end
  // Saturation guarantees a single strobe per stable period.
  assign w_stb = (r_s2 == r_sd) && (r_cnt == CNT_STB);
  assign w_an  = r_s2[10:7];
  assign w_seg = r_s2[6:0];
  always_comb begin
    w_dig    = 4'd0;
    w_is_dig = 1'b1;
    case (w_seg)
      7'b1000000: w_dig = 4'd0;
      7'b1111001: w_dig = 4'd1;
      7'b0100100: w_dig = 4'd2;
      7'b0110000: w_dig = 4'd3;
      7'b0011001: w_dig = 4'd4;
      7'b0010010: w_dig = 4'd5;
      7'b0000010: w_dig = 4'd6;
      7'b1111000: w_dig = 4'd7;
      7'b0000000: w_dig = 4'd8;
      7'b0011000: w_dig = 4'd9;
      default:    w_is_dig = 1'b0;
    endcase
  end
  assign w_blank = (w_seg == 7'b1111111);
  assign w_d0    = w_stb && (w_an == 4'b1110);
  assign w_d1    = w_stb && (w_an == 4'b1101);
  assign w_up    = w_stb && ((w_an == 4'b1011) || (w_an == 4'b0111));
  assign w_frame = {1'b0, r_tens, 3'b000} + {3'b000, r_tens, 1'b0} + {4'b0000, r_ones};
  always_comb begin
    w_state_n = r_state;
    w_ones_n  = r_ones;
    w_tens_n  = r_tens;
    w_ferr_n  = r_ferr;
    w_valid_n = 1'b0;
    w_perr_n  = 1'b0;
    if (w_d0 && !w_is_dig) begin
      w_perr_n  = 1'b1;
      w_state_n = SYNC;
    end else begin
      case (r_state)
        SYNC:
          if (w_d0) begin
            w_ones_n  = w_dig;
            w_ferr_n  = 1'b0;
            w_state_n = HAVE0;
          end
        HAVE0:
          if (w_d1) begin
            w_tens_n  = w_is_dig ? w_dig : 4'd0;
            w_ferr_n  = r_ferr | (!w_is_dig && !w_blank);
            w_state_n = HAVE1;
          end else if (w_d0) begin
            w_perr_n = 1'b1;
            w_ones_n = w_dig;
            w_ferr_n = 1'b0;
          end
        HAVE1:
          if (w_up && !w_blank) w_ferr_n = 1'b1;
          else if (w_d0) begin
            w_valid_n = !r_ferr;
            w_perr_n  = r_ferr;
            w_ones_n  = w_dig;
            w_ferr_n  = 1'b0;
            w_state_n = HAVE0;
          end
        default: w_state_n = SYNC;
      endcase
    end
  end
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state     <= SYNC;
      r_ones      <= '0;
      r_tens      <= '0;
      r_ferr      <= 1'b0;
      r_amt       <= '0;
      r_digit0    <= '0;
      r_digit1    <= '0;
      r_amt_valid <= 1'b0;
      r_pat_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_ones      <= w_ones_n;
      r_tens      <= w_tens_n;
      r_ferr      <= w_ferr_n;
      r_amt_valid <= w_valid_n;
      r_pat_err   <= w_perr_n;
      if (w_valid_n) begin
        r_amt    <= w_frame;
        r_digit0 <= r_ones;
        r_digit1 <= r_tens;
      end
    end
  assign amt       = r_amt;
  assign amt_valid = r_amt_valid;
  assign digit0    = r_digit0;
  assign digit1    = r_digit1;
  assign pat_err   = r_pat_err;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scan sequences with a scoreboard of expected frame results.
module tb_seg_scan_decoder;
  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0011000, BLK = 7'b1111111, ILL = 7'b0101010;
  typedef struct packed {
    logic       err;
    logic [7:0] amt;
    logic [3:0] d1;
    logic [3:0] d0;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] seg = 7'b1111111;
  logic [3:0] an = 4'b1111;
  logic [7:0] amt;
  logic       amt_valid, pat_err;
  logic [3:0] digit0, digit1;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       q[$];
  exp_t       m_e;
  always #5 clk = ~clk;
  seg_scan_decoder #(.STABLE_CYC(16)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .amt(amt), .amt_valid(amt_valid),
    .digit0(digit0), .digit1(digit1), .pat_err(pat_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic err, input int a, input int t, input int o);
    exp_t e;
    e.err = err;
    e.amt = 8'(a);
    e.d1  = 4'(t);
    e.d0  = 4'(o);
    q.push_back(e);
  endtask
  task automatic scan(input logic [6:0] d1, input logic [6:0] up, input logic [6:0] d0, input int n,
                      input logic err, input int a, input int t, input int o);
    show(4'b1101, d1, n);
    show(4'b1011, up, n);
    show(4'b0111, BLK, n);
    push(err, a, t, o);
    show(4'b1110, d0, n);
  endtask
  always @(negedge clk)
    if (reset && (amt_valid || pat_err)) begin
      chk("event_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        m_e = q.pop_front();
        chk("amt_valid", amt_valid, !m_e.err);
        chk("pat_err", pat_err, m_e.err);
        chk("amt", amt, m_e.amt);
        chk("digit1", digit1, m_e.d1);
        chk("digit0", digit0, m_e.d0);
      end
    end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_amt", amt, 0);
    chk("rst_digit0", digit0, 0);
    chk("rst_digit1", digit1, 0);
    chk("rst_amt_valid", amt_valid, 0);
    chk("rst_pat_err", pat_err, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    show(4'b1110, P7, 100);
    scan(P4, BLK, P7, 100, 1'b0, 47, 4, 7);
    show(4'b1101, P4, 8);
    show(4'b1101, P8, 5);
    show(4'b1101, P4, 100);
    show(4'b1011, BLK, 100);
    show(4'b0111, BLK, 100);
    push(1'b0, 47, 4, 7);
    show(4'b1110, P5, 100);
    scan(BLK, BLK, P5, 100, 1'b0, 5, 0, 5);
    scan(ILL, BLK, P5, 100, 1'b1, 5, 0, 5);
    show(4'b1101, P4, 100);
    push(1'b1, 5, 0, 5);
    show(4'b1110, ILL, 100);
    show(4'b1101, P3, 100);
    show(4'b1110, P2, 100);
    scan(P1, BLK, P2, 100, 1'b0, 12, 1, 2);
    push(1'b1, 12, 1, 2);
    show(4'b1110, P3, 100);
    scan(P6, BLK, P3, 100, 1'b0, 63, 6, 3);
    scan(P1, P8, P9, 100, 1'b1, 63, 6, 3);
    show(4'b1101, P9, 100);
    reset = 1'b0;
    #1;
    chk("midrst_amt", amt, 0);
    chk("midrst_digit0", digit0, 0);
    chk("midrst_digit1", digit1, 0);
    chk("midrst_amt_valid", amt_valid, 0);
    chk("midrst_pat_err", pat_err, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    show(4'b1101, P9, 100);
    show(4'b1011, BLK, 100);
    show(4'b0111, BLK, 100);
    show(4'b1110, P9, 100);
    scan(P9, BLK, P9, 100, 1'b0, 99, 9, 9);
    scan(BLK, BLK, P0, 30, 1'b0, 9, 0, 9);
    for (int i = 0; i < 10; i++) scan(BLK, BLK, P0, 30, 1'b0, 0, 0, 0);
    scan(P9, BLK, P9, 30, 1'b0, 90, 9, 0);
    for (int i = 0; i < 10; i++) scan(P9, BLK, P9, 30, 1'b0, 99, 9, 9);
    repeat (60) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYC, default 16: consecutive equal samples of {an,seg} required before a digit is accepted; legal range 2..255.
REQ-002 clk  input  1  100 MHz system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately, release is synchronous to clk.
REQ-004 seg  input  7  multiplexed 7-segment cathode pattern, active-low, bit order {g,f,e,d,c,b,a}; asynchronous to clk.
REQ-005 an  input  4  digit anode enables, active-low; asynchronous to clk.
REQ-006 amt  output  8  last completed frame value, binary, 0..99.
REQ-007 amt_valid  output  1  one-cycle pulse; amt updated this cycle.
REQ-008 digit0  output  4  last accepted ones digit, BCD.
REQ-009 digit1  output  4  last accepted tens digit, BCD; 0 when blank.
REQ-010 pat_err  output  1  one-cycle pulse; current frame discarded.

Function
REQ-011 seg and an SHALL pass through a two-flop synchroniser as one 11-bit vector S before any use.
REQ-012 S SHALL be compared each cycle with S delayed one cycle; 8-bit counter cnt SHALL clear on mismatch, otherwise increment, saturating at STABLE_CYC.
REQ-013 A sample strobe SHALL fire exactly once per stable period, in the cycle cnt goes from STABLE_CYC-1 to STABLE_CYC.
REQ-014 Decode SHALL map 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0011000 to 0..9; 1111111 is BLANK; any other pattern is ILLEGAL.
REQ-015 Strobe with an=1110 is a D0 sample, an=1101 a D1 sample, an=1011 or 0111 an UPPER sample; any other an value SHALL be ignored without state change.
REQ-016 FSM states: SYNC, HAVE0, HAVE1; reset state SYNC; frame-error flag ferr cleared on entering HAVE0.
REQ-017 SYNC: D0 sample of digit -> latch ones, HAVE0; all other samples ignored.
REQ-018 HAVE0: D1 digit -> latch tens, HAVE1; D1 BLANK -> tens=0, HAVE1; D1 ILLEGAL -> set ferr, HAVE1; D0 sample (D1 skipped) -> pat_err pulse, relatch ones, stay HAVE0.
REQ-019 HAVE1: UPPER sample not BLANK -> set ferr; D0 sample -> frame end.
REQ-020 Frame end: if ferr=0, amt=tens*10+ones, digit0/digit1 updated, amt_valid pulse; if ferr=1, pat_err pulse, outputs held; in both cases the new D0 digit starts the next frame (HAVE0).
REQ-021 D0 ILLEGAL or BLANK in any state SHALL pulse pat_err and go to SYNC.
REQ-022 amt_valid and pat_err SHALL assert in the cycle after the ending strobe and never together.
REQ-023 Latency from stable input at pins to strobe: 2 sync cycles + STABLE_CYC cycles.
REQ-024 tens*10+ones SHALL be computed in 8 bits using shift-add (x8+x2); no divider.
REQ-025 cnt saturation SHALL prevent re-strobing a held digit; a changed and re-stable vector SHALL strobe again, even if an is unchanged.

Reset
REQ-026 Reset low SHALL force FSM=SYNC, cnt=0, synchroniser and delay registers to all-ones, amt=0, digit0=0, digit1=0, amt_valid=0, pat_err=0, ferr=0.
REQ-027 Reset asserted mid-frame SHALL discard partial digits; no amt_valid until a full D0,D1,D0 sequence completes after release.

Verification
REQ-028 Scan an=1110/seg=1111000 (7), an=1101/seg=0011001 (4), an=1011,0111 blank, then an=1110 again, 100 cycles each -> amt_valid once, amt=47, digit1=4, digit0=7.
REQ-029 Tens blank (1111111) with ones 0010010 (5) -> amt=5, digit1=0.
REQ-030 During stable D1 phase, 5-cycle glitch seg=0000000 -> no strobe; result unchanged (amt=47).
REQ-031 D1 pattern 0101010 (ILLEGAL) -> at next D0, pat_err pulse, amt stays at previous value, amt_valid=0.
REQ-032 Assert reset after D1 accepted; release; one full scan of 99 -> first amt_valid carries 99; none before it.
REQ-033 Continuous scan of 0, then 99, each held 10 frames -> amt_valid every frame; amt 0 then 99; pat_err never asserted.
